color_frame_classifier: RTL and testbench



---
 rtl/color_frame_classifier_pkg.sv | 45 ++++
 rtl/color_frame_classifier_pixel.sv | 26 ++
 rtl/color_frame_classifier.sv | 139 +++++++++++++
 tb/tb_color_frame_classifier.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/color_frame_classifier_pkg.sv
// Shared encodings, RGB332 field positions and default thresholds for the colour pipeline.
package color_frame_classifier_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned RES_W   = 2;

    // RGB332 field layout
    localparam int unsigned R_MSB = 7;
    localparam int unsigned R_LSB = 5;
    localparam int unsigned G_MSB = 4;
    localparam int unsigned G_LSB = 2;
    localparam int unsigned B_MSB = 1;
    localparam int unsigned B_LSB = 0;
    localparam int unsigned R_W   = R_MSB - R_LSB + 1;
    localparam int unsigned G_W   = G_MSB - G_LSB + 1;
    localparam int unsigned B_W   = B_MSB - B_LSB + 1;

    // Fixed colour-purity limits on the non-dominant channels
    localparam int unsigned RED_G_MAX  = 2;
    localparam int unsigned RED_B_MAX  = 1;
    localparam int unsigned BLUE_R_MAX = 2;
    localparam int unsigned BLUE_G_MAX = 3;

    // Default image window and thresholds
    localparam int unsigned DEF_IMG_W     = 176;
    localparam int unsigned DEF_IMG_H     = 120;
    localparam int unsigned DEF_R_MIN     = 4;
    localparam int unsigned DEF_B_MIN     = 2;
    localparam int unsigned DEF_MIN_COUNT = 64;
    localparam int unsigned DEF_CNT_W     = 15;

    typedef enum logic [RES_W-1:0] {
        RES_NONE = 2'b00,
        RES_RED  = 2'b01,
        RES_BLUE = 2'b10
    } result_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCUM  = 2'b01,
        ST_DECIDE = 2'b10
    } state_e;

endpackage

// File: rtl/color_frame_classifier_pixel.sv
// Combinational RGB332 red/blue pixel classifier; a pixel can never be both.
module rgb332_pixel_classifier
    import color_frame_classifier_pkg::*;
(
    input  logic [PIX_W-1:0] pixel,
    input  logic [R_W-1:0]   r_min,
    input  logic [B_W-1:0]   b_min,
    output logic             is_red,
    output logic             is_blue
);

    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;

    assign r = pixel[R_MSB:R_LSB];
    assign g = pixel[G_MSB:G_LSB];
    assign b = pixel[B_MSB:B_LSB];

    // Dominant channel above its threshold, other channels kept low
    always_comb begin
        is_red  = (r >= r_min) && (g <= G_W'(RED_G_MAX))  && (b <= B_W'(RED_B_MAX));
        is_blue = (b >= b_min) && (r <= R_W'(BLUE_R_MAX)) && (g <= G_W'(BLUE_G_MAX));
    end

endmodule

// File: rtl/color_frame_classifier.sv
// Counts red/blue pixels in the image window each frame and issues a one-cycle verdict.
module color_frame_classifier
    import color_frame_classifier_pkg::*;
#(
    parameter int unsigned IMG_W     = DEF_IMG_W,
    parameter int unsigned IMG_H     = DEF_IMG_H,
    parameter int unsigned R_MIN     = DEF_R_MIN,
    parameter int unsigned B_MIN     = DEF_B_MIN,
    parameter int unsigned MIN_COUNT = DEF_MIN_COUNT,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [7:0]         PIXEL_IN,
    input  logic [9:0]         PIXEL_X,
    input  logic [9:0]         PIXEL_Y,
    output logic [1:0]         RESULT,
    output logic               RESULT_VALID,
    output logic [CNT_W-1:0]   RED_COUNT,
    output logic [CNT_W-1:0]   BLUE_COUNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state, state_nxt;
    logic             is_red, is_blue;
    logic             in_win, at_origin, at_last;
    logic             cnt_clr, cnt_load, cnt_acc, decide;
    logic [CNT_W-1:0] red_cnt, blue_cnt;
    result_e          verdict;

    rgb332_pixel_classifier u_pixel (
        .pixel   (PIXEL_IN),
        .r_min   (R_W'(R_MIN)),
        .b_min   (B_W'(B_MIN)),
        .is_red  (is_red),
        .is_blue (is_blue)
    );

    // Window position decode
    always_comb begin
        in_win    = (PIXEL_X < COORD_W'(IMG_W)) && (PIXEL_Y < COORD_W'(IMG_H));
        at_origin = in_win && (PIXEL_X == '0) && (PIXEL_Y == '0);
        at_last   = in_win && (PIXEL_X == COORD_W'(IMG_W - 1)) && (PIXEL_Y == COORD_W'(IMG_H - 1));
    end

    // Verdict from the completed frame counts; ties and low counts are NONE
    always_comb begin
        verdict = RES_NONE;
        if ((red_cnt >= CNT_W'(MIN_COUNT)) && (red_cnt > blue_cnt)) begin
            verdict = RES_RED;
        end else if ((blue_cnt >= CNT_W'(MIN_COUNT)) && (blue_cnt > red_cnt)) begin
            verdict = RES_BLUE;
        end
    end

    // State register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and counter controls; a frame restart at (0,0) reloads the counters
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_acc   = 1'b0;
        decide    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (at_origin) begin
                    cnt_load  = 1'b1;
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (at_origin) begin
                    cnt_load = 1'b1;
                end else if (in_win) begin
                    cnt_acc = 1'b1;
                    if (at_last) begin
                        state_nxt = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                decide    = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Saturating per-frame pixel counters
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            red_cnt  <= '0;
            blue_cnt <= '0;
        end else if (cnt_clr) begin
            red_cnt  <= '0;
            blue_cnt <= '0;
        end else if (cnt_load) begin
            red_cnt  <= CNT_W'(is_red);
            blue_cnt <= CNT_W'(is_blue);
        end else if (cnt_acc) begin
            if (is_red && (red_cnt != CNT_MAX)) begin
                red_cnt <= red_cnt + CNT_W'(1);
            end
            if (is_blue && (blue_cnt != CNT_MAX)) begin
                blue_cnt <= blue_cnt + CNT_W'(1);
            end
        end
    end

    // Registered verdict and frame counts, held until the next decision
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            RESULT       <= RES_NONE;
            RESULT_VALID <= 1'b0;
            RED_COUNT    <= '0;
            BLUE_COUNT   <= '0;
        end else begin
            RESULT_VALID <= decide;
            if (decide) begin
                RESULT     <= verdict;
                RED_COUNT  <= red_cnt;
                BLUE_COUNT <= blue_cnt;
            end
        end
    end

endmodule

// File: tb/tb_color_frame_classifier.sv
// Directed bench: full-size instance for full-frame cases, reduced-window instance for pattern tables.
module tb_color_frame_classifier;

    localparam int SW = 32;
    localparam int SH = 16;
    localparam int FW = 176;
    localparam int FH = 120;

    localparam int M_UNI     = 0;
    localparam int M_BLUE100 = 1;
    localparam int M_RED50   = 2;
    localparam int M_TIE     = 3;
    localparam int M_R201    = 4;
    localparam int M_BLANK   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pin;
    logic [9:0]  px, py;

    logic [1:0]  f_res, s_res;
    logic        f_val, s_val;
    logic [14:0] f_red, f_blue, s_red, s_blue;

    int checks = 0;
    int errors = 0;
    int f_pulses = 0;
    int s_pulses = 0;

    typedef struct {
        int         mode;
        logic [7:0] col;
        int         exp_res;
        int         exp_red;
        int         exp_blue;
    } vec_t;

    vec_t vecs[14];

    color_frame_classifier u_full (
        .CLOCK(clk), .RESET(rst), .PIXEL_IN(pin), .PIXEL_X(px), .PIXEL_Y(py),
        .RESULT(f_res), .RESULT_VALID(f_val), .RED_COUNT(f_red), .BLUE_COUNT(f_blue)
    );

    color_frame_classifier #(.IMG_W(SW), .IMG_H(SH)) u_small (
        .CLOCK(clk), .RESET(rst), .PIXEL_IN(pin), .PIXEL_X(px), .PIXEL_Y(py),
        .RESULT(s_res), .RESULT_VALID(s_val), .RED_COUNT(s_red), .BLUE_COUNT(s_blue)
    );

    always #20 clk = ~clk;

    // Count valid pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (f_val) f_pulses++;
        if (s_val) s_pulses++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] c);
        px  = 10'(x);
        py  = 10'(y);
        pin = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int mode, input logic [7:0] col, input int idx);
        case (mode)
            M_UNI:     return col;
            M_BLUE100: return (idx < 100) ? 8'h03 : 8'h00;
            M_RED50:   return (idx < 50) ? 8'hE0 : 8'h00;
            M_TIE:     return (idx < 200) ? 8'hE0 : ((idx < 400) ? 8'h03 : 8'h00);
            M_R201:    return (idx < 201) ? 8'hE0 : ((idx < 401) ? 8'h03 : 8'h00);
            default:   return 8'h00;
        endcase
    endfunction

    // Raster-order frame from index start_idx; M_BLANK adds red out-of-window cycles per line
    task automatic drive_frame(input int w, input int h, input int mode, input logic [7:0] col,
                               input int start_idx);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (y * w + x >= start_idx) pix(x, y, pat(mode, col, y * w + x));
            end
            if (mode == M_BLANK && y < h - 1) begin
                pix(w, y, 8'hE0);
                pix(w + 1, y, 8'hE0);
                pix(799, y, 8'hE0);
                pix(5, h + y, 8'hE0);
                pix(0, h, 8'hE0);
                pix(w, 524, 8'hE0);
            end
        end
    endtask

    // Called one step after the edge that sampled the last window pixel
    task automatic check_verdict(input bit full, input string tag, input int er, input int ered,
                                 input int eblue, input int base);
        chk({tag, "_valid_k"}, int'(full ? f_val : s_val), 0);
        pix(799, 524, 8'h00);
        chk({tag, "_valid_k1"}, int'(full ? f_val : s_val), 1);
        chk({tag, "_result"}, int'(full ? f_res : s_res), er);
        chk({tag, "_red"}, int'(full ? f_red : s_red), ered);
        chk({tag, "_blue"}, int'(full ? f_blue : s_blue), eblue);
        pix(799, 524, 8'h00);
        chk({tag, "_valid_k2"}, int'(full ? f_val : s_val), 0);
        chk({tag, "_pulses"}, (full ? f_pulses : s_pulses) - base, 1);
    endtask

    initial begin
        int base;

        vecs[0]  = '{M_BLUE100, 8'h00, 2, 0, 100};
        vecs[1]  = '{M_RED50,   8'h00, 0, 50, 0};
        vecs[2]  = '{M_TIE,     8'h00, 0, 200, 200};
        vecs[3]  = '{M_R201,    8'h00, 1, 201, 200};
        vecs[4]  = '{M_BLANK,   8'h00, 0, 0, 0};
        vecs[5]  = '{M_UNI,     8'h88, 1, 512, 0};
        vecs[6]  = '{M_UNI,     8'h89, 1, 512, 0};
        vecs[7]  = '{M_UNI,     8'h8A, 0, 0, 0};
        vecs[8]  = '{M_UNI,     8'h6C, 0, 0, 0};
        vecs[9]  = '{M_UNI,     8'h8C, 0, 0, 0};
        vecs[10] = '{M_UNI,     8'h4F, 2, 0, 512};
        vecs[11] = '{M_UNI,     8'h52, 0, 0, 0};
        vecs[12] = '{M_UNI,     8'h62, 0, 0, 0};
        vecs[13] = '{M_UNI,     8'h02, 2, 0, 512};

        rst = 1'b1;
        pin = 8'h00;
        px  = 10'd799;
        py  = 10'd524;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_full_result", int'(f_res), 0);
        chk("rst_full_valid", int'(f_val), 0);
        chk("rst_full_red", int'(f_red), 0);
        chk("rst_full_blue", int'(f_blue), 0);
        chk("rst_small_result", int'(s_res), 0);
        chk("rst_small_valid", int'(s_val), 0);
        chk("rst_small_red", int'(s_red), 0);
        chk("rst_small_blue", int'(s_blue), 0);
        rst = 1'b0;
        pix(799, 524, 8'h00);

        // Pattern frames on the reduced window
        for (int i = 0; i < 14; i++) begin
            base = s_pulses;
            drive_frame(SW, SH, vecs[i].mode, vecs[i].col, 0);
            check_verdict(1'b0, $sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_red,
                          vecs[i].exp_blue, base);
        end

        // Aborted frame: restart at (0,0) discards 300 red pixels
        base = s_pulses;
        for (int i = 0; i < 300; i++) pix(i % SW, i / SW, 8'hE0);
        drive_frame(SW, SH, M_BLUE100, 8'h00, 0);
        check_verdict(1'b0, "restart", 2, 0, 100, base);

        // Full-size red frame
        base = f_pulses;
        drive_frame(FW, FH, M_UNI, 8'hE0, 0);
        check_verdict(1'b1, "full_red", 1, 21120, 0, base);

        // Reset at (80,60) of a red frame, then rest of that frame and a full blue frame
        base = f_pulses;
        for (int i = 0; i < 60 * FW + 80; i++) pix(i % FW, i / FW, 8'hE0);
        px  = 10'd80;
        py  = 10'd60;
        pin = 8'hE0;
        rst = 1'b1;
        #1;
        chk("midrst_result", int'(f_res), 0);
        chk("midrst_red", int'(f_red), 0);
        chk("midrst_blue", int'(f_blue), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_frame(FW, FH, M_UNI, 8'hE0, 60 * FW + 81);
        pix(799, 524, 8'h00);
        pix(799, 524, 8'h00);
        chk("midrst_no_pulse", f_pulses - base, 0);
        drive_frame(FW, FH, M_UNI, 8'h03, 0);
        check_verdict(1'b1, "full_blue", 2, 0, 21120, base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
